// File: rtl/branch_predictor_bht.sv
// ---------------------------------------------------------------------------
// branch_predictor_bht
//   Dynamic branch predictor: a direct-mapped, tagged branch target buffer
//   with per-entry saturating direction counters.
//
//   IF side (combinational, 0-cycle latency):
//     if_pc                      fetch PC to look up
//     pred_hit / pred_taken      entry valid with matching tag / predict taken
//     pred_target                BTB target when predicted taken, else if_pc+4
//   EX side (resolution and training):
//     ex_valid, ex_is_branch     together qualify a resolving branch
//     ex_pc, ex_taken, ex_target resolved branch PC, direction and target
//     ex_pred_taken/target       prediction carried down from IF
//     mispredict, redirect_pc    same-cycle flush request and corrected PC
//   Performance:
//     perf_branches              resolved-branch count (saturating)
//     perf_mispredicts           misprediction count (saturating)
//   clk / rst                    rising-edge clock, synchronous active-high reset
// ---------------------------------------------------------------------------
module branch_predictor_bht #(
    parameter int PC_WIDTH   = 32,
    parameter int INDEX_BITS = 4,
    parameter int TAG_BITS   = 8,
    parameter int CTR_BITS   = 2,
    parameter int PERF_BITS  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PC_WIDTH-1:0]  if_pc,
    output logic                 pred_hit,
    output logic                 pred_taken,
    output logic [PC_WIDTH-1:0]  pred_target,
    input  logic                 ex_valid,
    input  logic                 ex_is_branch,
    input  logic [PC_WIDTH-1:0]  ex_pc,
    input  logic                 ex_taken,
    input  logic [PC_WIDTH-1:0]  ex_target,
    input  logic                 ex_pred_taken,
    input  logic [PC_WIDTH-1:0]  ex_pred_target,
    output logic                 mispredict,
    output logic [PC_WIDTH-1:0]  redirect_pc,
    output logic [PERF_BITS-1:0] perf_branches,
    output logic [PERF_BITS-1:0] perf_mispredicts
);

    localparam int ENTRIES  = 1 << INDEX_BITS;
    localparam int TAG_LO   = INDEX_BITS + 2;
    localparam int TAG_HI   = INDEX_BITS + TAG_BITS + 1;

    localparam logic [PC_WIDTH-1:0]  PC_STEP     = PC_WIDTH'(3'd4);
    localparam logic [CTR_BITS-1:0]  CTR_ZERO    = CTR_BITS'(1'b0);
    localparam logic [CTR_BITS-1:0]  CTR_ONE     = CTR_BITS'(1'b1);
    localparam logic [CTR_BITS-1:0]  CTR_MAX     = {CTR_BITS{1'b1}};
    // Weakly not-taken is 0111..., weakly taken is its complement 1000...
    localparam logic [CTR_BITS-1:0]  CTR_WEAK_NT = CTR_MAX >> 1;
    localparam logic [CTR_BITS-1:0]  CTR_WEAK_T  = ~CTR_WEAK_NT;
    localparam logic [PERF_BITS-1:0] PERF_ZERO   = PERF_BITS'(1'b0);
    localparam logic [PERF_BITS-1:0] PERF_ONE    = PERF_BITS'(1'b1);
    localparam logic [PERF_BITS-1:0] PERF_MAX    = {PERF_BITS{1'b1}};
    localparam logic [TAG_BITS-1:0]  TAG_ZERO    = TAG_BITS'(1'b0);
    localparam logic [PC_WIDTH-1:0]  PC_ZERO     = PC_WIDTH'(1'b0);

    logic                valid_r  [ENTRIES];
    logic [TAG_BITS-1:0] tag_r    [ENTRIES];
    logic [PC_WIDTH-1:0] target_r [ENTRIES];
    logic [CTR_BITS-1:0] ctr_r    [ENTRIES];

    logic [PERF_BITS-1:0] branches_r;
    logic [PERF_BITS-1:0] mispredicts_r;

    logic [INDEX_BITS-1:0] lk_idx_s;
    logic [TAG_BITS-1:0]   lk_tag_s;
    logic [INDEX_BITS-1:0] ex_idx_s;
    logic [TAG_BITS-1:0]   ex_tag_s;
    logic                  ex_hit_s;
    logic                  resolve_s;
    logic                  mispredict_s;

    // PC bits outside index/tag never influence the table.
    logic unused_pc_bits_s;
    assign unused_pc_bits_s = ^{if_pc[1:0], ex_pc[1:0],
                                if_pc[PC_WIDTH-1:TAG_HI+1], ex_pc[PC_WIDTH-1:TAG_HI+1]};

    assign lk_idx_s = if_pc[INDEX_BITS+1:2];
    assign lk_tag_s = if_pc[TAG_HI:TAG_LO];
    assign ex_idx_s = ex_pc[INDEX_BITS+1:2];
    assign ex_tag_s = ex_pc[TAG_HI:TAG_LO];

    // IF-stage lookup against pre-update table contents.
    always_comb begin
        pred_hit    = valid_r[lk_idx_s] && (tag_r[lk_idx_s] == lk_tag_s);
        pred_taken  = pred_hit && ctr_r[lk_idx_s][CTR_BITS-1];
        if (pred_taken) begin
            pred_target = target_r[lk_idx_s];
        end else begin
            pred_target = if_pc + PC_STEP;
        end
    end

    // EX-stage resolution: detect wrong direction or wrong taken target.
    always_comb begin
        resolve_s    = ex_valid && ex_is_branch;
        ex_hit_s     = valid_r[ex_idx_s] && (tag_r[ex_idx_s] == ex_tag_s);
        mispredict_s = resolve_s &&
                       ((ex_taken != ex_pred_taken) ||
                        (ex_taken && (ex_target != ex_pred_target)));
        mispredict   = mispredict_s;
        if (ex_taken) begin
            redirect_pc = ex_target;
        end else begin
            redirect_pc = ex_pc + PC_STEP;
        end
    end

    // Table training on resolved branches.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_r[i]  <= 1'b0;
                tag_r[i]    <= TAG_ZERO;
                target_r[i] <= PC_ZERO;
                ctr_r[i]    <= CTR_WEAK_NT;
            end
        end else if (resolve_s) begin
            if (ex_hit_s) begin
                if (ex_taken) begin
                    target_r[ex_idx_s] <= ex_target;
                    if (ctr_r[ex_idx_s] != CTR_MAX) begin
                        ctr_r[ex_idx_s] <= ctr_r[ex_idx_s] + CTR_ONE;
                    end
                end else if (ctr_r[ex_idx_s] != CTR_ZERO) begin
                    ctr_r[ex_idx_s] <= ctr_r[ex_idx_s] - CTR_ONE;
                end
            end else if (ex_taken) begin
                // Taken miss: allocate, evicting any aliasing entry.
                valid_r[ex_idx_s]  <= 1'b1;
                tag_r[ex_idx_s]    <= ex_tag_s;
                target_r[ex_idx_s] <= ex_target;
                ctr_r[ex_idx_s]    <= CTR_WEAK_T;
            end
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            branches_r    <= PERF_ZERO;
            mispredicts_r <= PERF_ZERO;
        end else begin
            if (resolve_s && (branches_r != PERF_MAX)) begin
                branches_r <= branches_r + PERF_ONE;
            end
            if (mispredict_s && (mispredicts_r != PERF_MAX)) begin
                mispredicts_r <= mispredicts_r + PERF_ONE;
            end
        end
    end

    assign perf_branches    = branches_r;
    assign perf_mispredicts = mispredicts_r;

endmodule

// File: tb/tb_branch_predictor_bht.sv
// ---------------------------------------------------------------------------
// tb_branch_predictor_bht
//   Directed self-checking bench for branch_predictor_bht with default
//   parameters. Inputs change 1 time unit after a rising edge and outputs
//   are observed before the following edge.
// ---------------------------------------------------------------------------
module tb_branch_predictor_bht;

    logic        clk;
    logic        rst;
    logic [31:0] if_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic        ex_is_branch;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] perf_branches;
    logic [31:0] perf_mispredicts;

    int checks;
    int errors;

    branch_predictor_bht dut (
        .clk              (clk),
        .rst              (rst),
        .if_pc            (if_pc),
        .pred_hit         (pred_hit),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .ex_valid         (ex_valid),
        .ex_is_branch     (ex_is_branch),
        .ex_pc            (ex_pc),
        .ex_taken         (ex_taken),
        .ex_target        (ex_target),
        .ex_pred_taken    (ex_pred_taken),
        .ex_pred_target   (ex_pred_target),
        .mispredict       (mispredict),
        .redirect_pc      (redirect_pc),
        .perf_branches    (perf_branches),
        .perf_mispredicts (perf_mispredicts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ex_idle();
        ex_valid       = 1'b0;
        ex_is_branch   = 1'b0;
        ex_pc          = 32'h0;
        ex_taken       = 1'b0;
        ex_target      = 32'h0;
        ex_pred_taken  = 1'b0;
        ex_pred_target = 32'h0;
    endtask

    task automatic ex_drive(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                            input logic ptk, input logic [31:0] ptgt);
        ex_valid       = 1'b1;
        ex_is_branch   = 1'b1;
        ex_pc          = pc;
        ex_taken       = tk;
        ex_target      = tgt;
        ex_pred_taken  = ptk;
        ex_pred_target = ptgt;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        if_pc = 32'h100;
        ex_idle();
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++; if (pred_hit !== 1'b0) begin errors++; $display("FAIL reset_hit got %0b exp 0", pred_hit); end
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL reset_taken got %0b exp 0", pred_taken); end
        checks++; if (pred_target !== 32'h104) begin errors++; $display("FAIL reset_target got %h exp 104", pred_target); end
        checks++; if (perf_branches !== 32'd0) begin errors++; $display("FAIL reset_perf_br got %0d exp 0", perf_branches); end
        checks++; if (perf_mispredicts !== 32'd0) begin errors++; $display("FAIL reset_perf_mp got %0d exp 0", perf_mispredicts); end
    endtask

    task automatic test_allocate();
        ex_drive(32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        #1;
        checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL alloc_mp got %0b exp 1", mispredict); end
        checks++; if (redirect_pc !== 32'h80) begin errors++; $display("FAIL alloc_redirect got %h exp 80", redirect_pc); end
        tick();
        ex_idle();
        #1;
        checks++; if (pred_hit !== 1'b1) begin errors++; $display("FAIL alloc_hit got %0b exp 1", pred_hit); end
        checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL alloc_taken got %0b exp 1", pred_taken); end
        checks++; if (pred_target !== 32'h80) begin errors++; $display("FAIL alloc_target got %h exp 80", pred_target); end
        checks++; if (perf_branches !== 32'd1) begin errors++; $display("FAIL alloc_perf_br got %0d exp 1", perf_branches); end
        checks++; if (perf_mispredicts !== 32'd1) begin errors++; $display("FAIL alloc_perf_mp got %0d exp 1", perf_mispredicts); end
    endtask

    task automatic test_train_down();
        // ctr 2 -> 1: predicted taken, resolved not taken
        ex_drive(32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
        #1;
        checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL down1_mp got %0b exp 1", mispredict); end
        checks++; if (redirect_pc !== 32'h104) begin errors++; $display("FAIL down1_redirect got %h exp 104", redirect_pc); end
        tick();
        ex_idle();
        #1;
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL down1_taken got %0b exp 0", pred_taken); end
        checks++; if (pred_target !== 32'h104) begin errors++; $display("FAIL down1_target got %h exp 104", pred_target); end
        // ctr 1 -> 0: correctly predicted not taken
        ex_drive(32'h100, 1'b0, 32'h80, 1'b0, 32'h104);
        #1;
        checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL down2_mp got %0b exp 0", mispredict); end
        tick();
        ex_idle();
        #1;
        checks++; if (pred_hit !== 1'b1) begin errors++; $display("FAIL down2_hit got %0b exp 1", pred_hit); end
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL down2_taken got %0b exp 0", pred_taken); end
        checks++; if (perf_branches !== 32'd3) begin errors++; $display("FAIL down2_perf_br got %0d exp 3", perf_branches); end
        checks++; if (perf_mispredicts !== 32'd2) begin errors++; $display("FAIL down2_perf_mp got %0d exp 2", perf_mispredicts); end
    endtask

    task automatic test_saturate();
        // ctr 0 -> 1 -> 2 -> 3 -> 3
        for (int i = 0; i < 4; i++) begin
            ex_drive(32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
            tick();
        end
        ex_idle();
        #1;
        checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL sat_taken got %0b exp 1", pred_taken); end
        // ctr 3 -> 2, still taken (a wrapped counter would fall to not taken)
        ex_drive(32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
        tick();
        ex_idle();
        #1;
        checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL sat_dec_taken got %0b exp 1", pred_taken); end
        checks++; if (pred_target !== 32'h80) begin errors++; $display("FAIL sat_dec_target got %h exp 80", pred_target); end
        // ctr 2 -> 1 confirms the counter sat at 3 rather than wrapping
        ex_drive(32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
        tick();
        ex_idle();
        #1;
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL sat_dec2_taken got %0b exp 0", pred_taken); end
        checks++; if (perf_branches !== 32'd9) begin errors++; $display("FAIL sat_perf_br got %0d exp 9", perf_branches); end
        checks++; if (perf_mispredicts !== 32'd4) begin errors++; $display("FAIL sat_perf_mp got %0d exp 4", perf_mispredicts); end
    endtask

    task automatic test_alias();
        ex_drive(32'h140, 1'b1, 32'h300, 1'b0, 32'h144);
        tick();
        ex_idle();
        if_pc = 32'h100;
        #1;
        checks++; if (pred_hit !== 1'b0) begin errors++; $display("FAIL alias_evicted_hit got %0b exp 0", pred_hit); end
        checks++; if (pred_target !== 32'h104) begin errors++; $display("FAIL alias_evicted_target got %h exp 104", pred_target); end
        if_pc = 32'h140;
        #1;
        checks++; if (pred_hit !== 1'b1) begin errors++; $display("FAIL alias_new_hit got %0b exp 1", pred_hit); end
        checks++; if (pred_target !== 32'h300) begin errors++; $display("FAIL alias_new_target got %h exp 300", pred_target); end
    endtask

    task automatic test_same_cycle();
        if_pc = 32'h200;
        ex_drive(32'h200, 1'b1, 32'h400, 1'b0, 32'h204);
        #1;
        checks++; if (pred_hit !== 1'b0) begin errors++; $display("FAIL same_cycle_hit got %0b exp 0", pred_hit); end
        checks++; if (pred_target !== 32'h204) begin errors++; $display("FAIL same_cycle_target got %h exp 204", pred_target); end
        tick();
        ex_idle();
        #1;
        checks++; if (pred_hit !== 1'b1) begin errors++; $display("FAIL next_cycle_hit got %0b exp 1", pred_hit); end
        checks++; if (pred_target !== 32'h400) begin errors++; $display("FAIL next_cycle_target got %h exp 400", pred_target); end
        checks++; if (perf_branches !== 32'd11) begin errors++; $display("FAIL same_perf_br got %0d exp 11", perf_branches); end
        checks++; if (perf_mispredicts !== 32'd6) begin errors++; $display("FAIL same_perf_mp got %0d exp 6", perf_mispredicts); end
    endtask

    task automatic test_non_branch();
        ex_drive(32'h104, 1'b1, 32'h500, 1'b0, 32'h108);
        ex_valid = 1'b0;
        #1;
        checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL bubble_mp got %0b exp 0", mispredict); end
        tick();
        ex_valid = 1'b1;
        ex_is_branch = 1'b0;
        #1;
        checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL nonbr_mp got %0b exp 0", mispredict); end
        tick();
        ex_idle();
        if_pc = 32'h104;
        #1;
        checks++; if (pred_hit !== 1'b0) begin errors++; $display("FAIL nonbr_table_hit got %0b exp 0", pred_hit); end
        checks++; if (perf_branches !== 32'd11) begin errors++; $display("FAIL nonbr_perf_br got %0d exp 11", perf_branches); end
        checks++; if (perf_mispredicts !== 32'd6) begin errors++; $display("FAIL nonbr_perf_mp got %0d exp 6", perf_mispredicts); end
    endtask

    task automatic test_mid_reset();
        rst = 1'b1;
        ex_drive(32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        #1;
        checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL rst_mp_follows got %0b exp 1", mispredict); end
        tick();
        rst = 1'b0;
        ex_idle();
        if_pc = 32'h200;
        #1;
        checks++; if (pred_hit !== 1'b0) begin errors++; $display("FAIL rst_hit_200 got %0b exp 0", pred_hit); end
        if_pc = 32'h100;
        #1;
        checks++; if (pred_hit !== 1'b0) begin errors++; $display("FAIL rst_hit_100 got %0b exp 0", pred_hit); end
        checks++; if (perf_branches !== 32'd0) begin errors++; $display("FAIL rst_perf_br got %0d exp 0", perf_branches); end
        checks++; if (perf_mispredicts !== 32'd0) begin errors++; $display("FAIL rst_perf_mp got %0d exp 0", perf_mispredicts); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_allocate();
        test_train_down();
        test_saturate();
        test_alias();
        test_same_cycle();
        test_non_branch();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
